// File: rtl/piso_stream_ser_if.sv
// Handshake bundle for piso_stream_ser: parallel load side and serial output side.
// The master modport is the producer/consumer environment; the slave modport is the serialiser.
interface piso_stream_ser_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] par_data;
   logic             par_valid;
   logic             par_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_last;
   logic             busy;

   modport master (
      output par_data, par_valid, ser_ready,
      input  par_ready, ser_out, ser_valid, ser_last, busy
   );

   modport slave (
      input  par_data, par_valid, ser_ready,
      output par_ready, ser_out, ser_valid, ser_last, busy
   );
endinterface

// File: rtl/piso_stream_ser.sv
// piso_stream_ser: parametrised parallel-in/serial-out shifter with valid/ready on both
// sides, stall support, frame-last marker and zero-bubble back-to-back frames.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_stream_ser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   piso_stream_ser_if.slave bus
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               r_state;
   logic [FRAME_LEN-1:0] r_shreg;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_active;
   logic                 w_last;
   logic                 w_bitBeat;
   logic                 w_parReady;
   logic                 w_loadBeat;
   logic [FRAME_LEN-1:0] w_loadWord;
   logic [FRAME_LEN-1:0] w_shifted;

   assign w_active   = (r_state == SHIFT);
   assign w_last     = w_active && (r_cnt == LAST_CNT);
   assign w_bitBeat  = w_active && bus.ser_ready;
   // A new word may enter while the last bit of the current frame is being taken,
   // which is what removes the idle bubble between frames.
   assign w_parReady = !w_active || (w_last && bus.ser_ready);
   assign w_loadBeat = bus.par_valid && w_parReady;

`ifdef PISO_PARITY_EN
   // The parity bit rides in the shift register at the far end so it leaves last.
   logic w_parity;
   assign w_parity   = ^bus.par_data;
   assign w_loadWord = MSB_FIRST ? {bus.par_data, w_parity} : {w_parity, bus.par_data};
`else
   assign w_loadWord = bus.par_data;
`endif

   assign w_shifted = MSB_FIRST ? {r_shreg[FRAME_LEN-2:0], 1'b0}
                                : {1'b0, r_shreg[FRAME_LEN-1:1]};

   assign bus.par_ready = w_parReady;
   assign bus.ser_valid = w_active;
   assign bus.busy      = w_active;
   assign bus.ser_last  = w_last;
   assign bus.ser_out   = w_active && (MSB_FIRST ? r_shreg[FRAME_LEN-1] : r_shreg[0]);

   // Frame sequencer: load a word, shift it out one bit per accepted beat, hold on stall,
   // and either return to IDLE or chain straight into the next word after the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_loadBeat) begin
         r_state <= SHIFT;
         r_shreg <= w_loadWord;
         r_cnt   <= '0;
      end else if (w_bitBeat) begin
         r_shreg <= w_shifted;
         if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/piso_stream_ser.md
Name: piso_stream_ser

Overview:
- Parametrised parallel-in/serial-out shifter; successor to the team's fixed 4-bit PISO.
- Adds configurable width and bit order, a valid/ready load handshake and a serial-side valid/ready with stall.
- Adds a frame-last marker and zero-bubble back-to-back frames.
- Sits between a parallel word producer and a bit-serial link or serial test port.

Parameters:
- WIDTH, 8, parallel word width in bits (>= 2).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- par_data  input  WIDTH  parallel word to serialise.
- par_valid  input  1  par_data is valid.
- par_ready  output  1  block accepts a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream consumes ser_out this cycle.
- ser_last  output  1  ser_out is the final bit of the frame.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid = 0, ser_last = 0, busy = 0.
  - par_ready = 1 once rst_n is high.
- FSM states: IDLE, SHIFT. Beat rules:
  - Load beat = par_valid & par_ready at a rising edge.
  - Bit beat = ser_valid & ser_ready at a rising edge.
- IDLE:
  - par_ready = 1; ser_valid = 0; ser_out = 0.
  - A load beat captures par_data into the shift register, sets cnt = 0 and moves to SHIFT.
- SHIFT:
  - ser_valid = 1.
  - ser_out = shreg[WIDTH-1] when MSB_FIRST = 1, else shreg[0].
  - On a bit beat: shift toward the output end (zero fill) and cnt++.
  - Without a bit beat: shreg, cnt and ser_out hold (stall). There is no stall time-out.
- Frame end:
  - ser_last = 1 when cnt == WIDTH-1 (FRAME_LEN-1 with the optional feature).
  - On the bit beat with ser_last = 1: go to IDLE, unless a load beat occurs in the same cycle.
- Back-to-back frames:
  - par_ready = (state == IDLE) | (ser_last & ser_ready). This is combinational from state and ser_ready.
  - A simultaneous last-bit beat and load beat loads the new word, sets cnt = 0 and stays in SHIFT, so there is no idle bubble.
  - par_ready is 0 during SHIFT except on an accepted last bit. par_data is ignored while par_ready is 0.
- Latency:
  - Load beat at edge N gives the first bit valid after edge N.
  - An unstalled WIDTH-bit frame occupies exactly WIDTH cycles.
- Outputs ser_out, ser_valid, ser_last and busy are registered or decoded from registered state only; no combinational path from par_*.
- ser_ready with ser_valid = 0 is ignored.
- Counter is sized clog2(FRAME_LEN); it never exceeds FRAME_LEN-1.
- Reset mid-frame:
  - Immediately discards the frame; outputs take their reset values.
  - No partial frame resumes after rst_n deasserts.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - Even-parity bit (XOR of the loaded word, captured at the load beat) is sent after the data bits.
  - ser_last is asserted on the parity bit, not the last data bit.
  - Back-to-back rule applies at the parity bit.
- Undefined: FRAME_LEN = WIDTH; no parity logic or storage is synthesised.

Test Plan:
- Bit order, MSB first (WIDTH=4, MSB_FIRST=1, ser_ready=1): load 4'b1010 -> ser_out 1,0,1,0 on 4 consecutive cycles; ser_last only on the 4th; ser_valid 0 on the 5th.
- Bit order, LSB first (MSB_FIRST=0): load 4'b1010 -> ser_out 0,1,0,1.
- Stall (WIDTH=4, MSB_FIRST=1): load 4'b1100; drop ser_ready for 3 cycles after the first bit -> ser_out holds 1 and ser_valid stays 1 through the stall; the stream resumes 1,0,0; total 7 cycles; par_ready 0 throughout.
- Back-to-back: par_valid held with 4'b1010 then 4'b0110 -> 8 contiguous valid bits 1,0,1,0,0,1,1,0; par_ready pulses with the 1st ser_last; ser_last on bits 4 and 8.
- Reset mid-frame: assert rst_n=0 after 2 of 4 bits -> ser_valid, ser_out and busy go 0 without waiting for a clock edge; after release par_ready=1 and a fresh 4'b0011 serialises fully as 0,0,1,1.
- Parity (PISO_PARITY_EN, WIDTH=4, MSB first): load 4'b1011 -> ser_out 1,0,1,1,1; ser_last on the 5th bit. Load 4'b1001 -> parity bit 0.
